// File: rtl/hazard_fwd_unit_if.sv
// Decode-side bundle for hazard_fwd_unit: decode operand/destination info in, stall and operand selects out.
// Ports: dec_valid/dec_rs/dec_rt/dec_use_rs/dec_use_rt/dec_wr_en/dec_wr_addr/dec_is_load/flush (decode -> unit),
//        stall/fwd_a/fwd_b/stall_cycles (unit -> decode/ALU mux). master = decode side, slave = the unit.
interface hazard_fwd_if #(
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
);
  logic             dec_valid;
  logic [4:0]       dec_rs;
  logic [4:0]       dec_rt;
  logic             dec_use_rs;
  logic             dec_use_rt;
  logic             dec_wr_en;
  logic [4:0]       dec_wr_addr;
  logic             dec_is_load;
  logic             flush;
  logic             stall;
  logic [SEL_W-1:0] fwd_a;
  logic [SEL_W-1:0] fwd_b;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output dec_valid, dec_rs, dec_rt, dec_use_rs, dec_use_rt,
           dec_wr_en, dec_wr_addr, dec_is_load, flush,
    input  stall, fwd_a, fwd_b, stall_cycles
  );

  modport slave (
    input  dec_valid, dec_rs, dec_rt, dec_use_rs, dec_use_rt,
           dec_wr_en, dec_wr_addr, dec_is_load, flush,
    output stall, fwd_a, fwd_b, stall_cycles
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding tracker: remembers the destinations of the last DEPTH issued instructions and
// picks the youngest forwarding source per operand; stalls decode while a load result is not yet forwardable.
// Ports: clk, reset (sync, active-high), bus (hazard_fwd_if.slave). stall/fwd_* are combinational, zero-latency.
module hazard_fwd_unit #(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = 3,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_fwd_if.slave   bus
);

  // entry k holds the instruction that left decode k cycles ago (1 = youngest)
  logic [DEPTH:1] ent_v;
  logic [DEPTH:1] ent_ld;
  logic [4:0]     ent_addr [1:DEPTH];

  logic [SEL_W-1:0] sel_a, sel_b;
  logic             ld_a, ld_b;
  logic             use_a, use_b;
  logic             stall_i;
  logic             ins_v;
  logic [CNT_W-1:0] stall_cnt;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  // ld_* marks a match whose load data is still in flight (not yet forwardable).
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (ent_v[k] && (ent_addr[k] == bus.dec_rs) && (bus.dec_rs != 5'd0)) begin
        sel_a = SEL_W'(k);
        ld_a  = ent_ld[k] && (k <= LOAD_LAT);
      end
      if (ent_v[k] && (ent_addr[k] == bus.dec_rt) && (bus.dec_rt != 5'd0)) begin
        sel_b = SEL_W'(k);
        ld_b  = ent_ld[k] && (k <= LOAD_LAT);
      end
    end
  end

  // reset masks all operand use so outputs are quiet while in reset
  assign use_a   = bus.dec_valid && bus.dec_use_rs && !reset;
  assign use_b   = bus.dec_valid && bus.dec_use_rt && !reset;
  // flush kills the decode instruction, so its hazard never matters
  assign stall_i = ((use_a && ld_a) || (use_b && ld_b)) && !bus.flush;

  assign bus.stall        = stall_i;
  assign bus.fwd_a        = (use_a && !stall_i) ? sel_a : '0;
  assign bus.fwd_b        = (use_b && !stall_i) ? sel_b : '0;
  assign bus.stall_cycles = stall_cnt;

  // a stalled or flushed slot enters the pipe as a bubble; $0 writes are never tracked
  assign ins_v = bus.dec_valid && bus.dec_wr_en && (bus.dec_wr_addr != 5'd0)
                 && !stall_i && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_v     <= '0;
      stall_cnt <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        ent_v[k] <= ent_v[k-1];
      end
      ent_v[1] <= ins_v;
      if (stall_i && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  // payload is only meaningful where ent_v is set, so it needs no reset
  always_ff @(posedge clk) begin
    for (int k = DEPTH; k >= 2; k--) begin
      ent_addr[k] <= ent_addr[k-1];
      ent_ld[k]   <= ent_ld[k-1];
    end
    ent_addr[1] <= bus.dec_wr_addr;
    ent_ld[1]   <= bus.dec_is_load;
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: two configurations driven with identical stimulus,
// directed scenarios with literal expectations, then randomized traffic against a history model.
// Checks run every negedge; inputs change 1 time unit after posedge.
module tb_hazard_fwd_unit;

  logic clk = 1'b0;
  logic reset;
  logic dec_valid, dec_use_rs, dec_use_rt, dec_wr_en, dec_is_load, flush;
  logic [4:0] dec_rs, dec_rt, dec_wr_addr;

  always #5 clk = ~clk;

  hazard_fwd_if #(.SEL_W(3), .CNT_W(4))  i0 ();
  hazard_fwd_if #(.SEL_W(3), .CNT_W(16)) i1 ();

  assign i0.dec_valid = dec_valid;   assign i1.dec_valid = dec_valid;
  assign i0.dec_rs = dec_rs;         assign i1.dec_rs = dec_rs;
  assign i0.dec_rt = dec_rt;         assign i1.dec_rt = dec_rt;
  assign i0.dec_use_rs = dec_use_rs; assign i1.dec_use_rs = dec_use_rs;
  assign i0.dec_use_rt = dec_use_rt; assign i1.dec_use_rt = dec_use_rt;
  assign i0.dec_wr_en = dec_wr_en;   assign i1.dec_wr_en = dec_wr_en;
  assign i0.dec_wr_addr = dec_wr_addr; assign i1.dec_wr_addr = dec_wr_addr;
  assign i0.dec_is_load = dec_is_load; assign i1.dec_is_load = dec_is_load;
  assign i0.flush = flush;           assign i1.flush = flush;

  hazard_fwd_unit #(.DEPTH(2), .LOAD_LAT(1), .SEL_W(3), .CNT_W(4)) u0 (
    .clk(clk), .reset(reset), .bus(i0)
  );
  hazard_fwd_unit #(.DEPTH(4), .LOAD_LAT(2), .SEL_W(3), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .bus(i1)
  );

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[n][i] = what left decode i+1 cycles ago in configuration n
  typedef struct packed { logic v; logic [4:0] a; logic ld; } rec_t;
  rec_t hist [2][8];
  int   mcnt [2];
  int   dep  [2] = '{2, 4};
  int   lat  [2] = '{1, 2};
  int   cmax [2] = '{15, 65535};

  function automatic int youngest(input int n, input logic [4:0] r);
    if (r == 5'd0) return 0;
    for (int i = 0; i < dep[n]; i++)
      if (hist[n][i].v && hist[n][i].a == r) return i + 1;
    return 0;
  endfunction

  function automatic void mdl(input int n, output bit st, output int fa, output int fb);
    int  ka, kb;
    bit  ua, ub, ha, hb;
    ka = youngest(n, dec_rs);
    kb = youngest(n, dec_rt);
    ua = !reset && dec_valid && dec_use_rs;
    ub = !reset && dec_valid && dec_use_rt;
    ha = ua && ka > 0 && hist[n][ka-1].ld && ka <= lat[n];
    hb = ub && kb > 0 && hist[n][kb-1].ld && kb <= lat[n];
    st = (ha || hb) && !flush && !reset;
    fa = (ua && !st) ? ka : 0;
    fb = (ub && !st) ? kb : 0;
  endfunction

  always @(posedge clk) begin
    bit st;
    int fa, fb;
    for (int n = 0; n < 2; n++) begin
      if (reset) begin
        for (int i = 0; i < 8; i++) hist[n][i].v <= 1'b0;
        mcnt[n] <= 0;
      end else begin
        mdl(n, st, fa, fb);
        if (st && mcnt[n] < cmax[n]) mcnt[n] <= mcnt[n] + 1;
        for (int i = 7; i >= 1; i--) hist[n][i] <= hist[n][i-1];
        hist[n][0] <= {(!st && !flush && dec_valid && dec_wr_en && dec_wr_addr != 5'd0),
                       dec_wr_addr, dec_is_load};
      end
    end
  end

  always @(negedge clk) begin
    bit st;
    int fa, fb;
    if (chk_en) begin
      mdl(0, st, fa, fb);
      chk("m0_stall", int'(i0.stall), int'(st));
      chk("m0_fwd_a", int'(i0.fwd_a), fa);
      chk("m0_fwd_b", int'(i0.fwd_b), fb);
      chk("m0_cnt",   int'(i0.stall_cycles), mcnt[0]);
      mdl(1, st, fa, fb);
      chk("m1_stall", int'(i1.stall), int'(st));
      chk("m1_fwd_a", int'(i1.fwd_a), fa);
      chk("m1_fwd_b", int'(i1.fwd_b), fb);
      chk("m1_cnt",   int'(i1.stall_cycles), mcnt[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                     input bit wen, input int wa, input bit ld, input bit fl);
    dec_valid   = v;
    dec_rs      = 5'(rs);
    dec_rt      = 5'(rt);
    dec_use_rs  = urs;
    dec_use_rt  = urt;
    dec_wr_en   = wen;
    dec_wr_addr = 5'(wa);
    dec_is_load = ld;
    flush       = fl;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    nop();
    nxt();
    chk_en = 1'b1;
    nxt();
    reset = 1'b0;

    // T1: fill with loads to $7, then reset for one cycle
    drv(1, 0, 0, 0, 0, 1, 7, 1, 0); nxt();
    drv(1, 0, 0, 0, 0, 1, 7, 1, 0); nxt();
    reset = 1'b1;
    drv(1, 7, 7, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1_rst_stall", int'(i0.stall), 0);
    chk("t1_rst_fwd_a", int'(i0.fwd_a), 0);
    nxt();
    reset = 1'b0;
    @(negedge clk);
    chk("t1_stall", int'(i0.stall), 0);
    chk("t1_fwd_a", int'(i0.fwd_a), 0);
    chk("t1_cnt", int'(i0.stall_cycles), 0);
    nxt();

    // T2: ALU chain
    drv(1, 0, 0, 0, 0, 1, 3, 0, 0); nxt();
    drv(1, 3, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("t2_fwd_a_1", int'(i0.fwd_a), 1); nxt();
    @(negedge clk); chk("t2_fwd_a_2", int'(i0.fwd_a), 2); nxt();
    @(negedge clk); chk("t2_fwd_a_0", int'(i0.fwd_a), 0); nxt();

    // T3: load-use
    drv(1, 0, 0, 0, 0, 1, 5, 1, 0); nxt();
    drv(1, 0, 5, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3_stall", int'(i0.stall), 1);
    chk("t3_fwd_b_stall", int'(i0.fwd_b), 0);
    nxt();
    @(negedge clk);
    chk("t3_release", int'(i0.stall), 0);
    chk("t3_fwd_b", int'(i0.fwd_b), 2);
    chk("t3_cnt", int'(i0.stall_cycles), 1);
    nxt();

    // T4: youngest wins
    drv(1, 0, 0, 0, 0, 1, 4, 0, 0); nxt();
    drv(1, 0, 0, 0, 0, 1, 4, 0, 0); nxt();
    drv(1, 4, 4, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4_fwd_a", int'(i0.fwd_a), 1);
    chk("t4_fwd_b", int'(i0.fwd_b), 1);
    nxt();

    // T5: $0 never forwards or stalls
    drv(1, 0, 0, 0, 0, 1, 0, 0, 0); nxt();
    drv(1, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5_fwd_a", int'(i0.fwd_a), 0);
    chk("t5_stall", int'(i0.stall), 0);
    nxt();
    drv(1, 0, 0, 0, 0, 1, 0, 1, 0); nxt();
    drv(1, 0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk); chk("t5_ld0_stall", int'(i0.stall), 0); nxt();

    // T6: flushed load is not recorded; flush masks a same-cycle hazard
    drv(1, 0, 0, 0, 0, 1, 6, 1, 1); nxt();
    drv(1, 6, 6, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6_stall", int'(i0.stall), 0);
    chk("t6_fwd_a", int'(i0.fwd_a), 0);
    chk("t6_fwd_b", int'(i0.fwd_b), 0);
    nxt();
    drv(1, 0, 0, 0, 0, 1, 6, 1, 0); nxt();
    drv(1, 6, 0, 1, 0, 0, 0, 0, 1);
    @(negedge clk); chk("t6_flush_stall", int'(i0.stall), 0); nxt();
    nop();
    @(negedge clk); chk("t6_cnt", int'(i0.stall_cycles), 1); nxt();

    // T7: self-dependent loads stall every other cycle; 4-bit counter saturates
    for (int i = 0; i < 44; i++) begin
      drv(1, 9, 0, 1, 0, 1, 9, 1, 0);
      nxt();
    end
    nop();
    @(negedge clk); chk("t7_sat", int'(i0.stall_cycles), 15); nxt();

    // randomized traffic, small register range to provoke matches
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drv($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 7),
          $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      nxt();
    end

    reset = 1'b0;
    nop();
    nxt();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
